// File: rtl/wt_fetch_ctrl_pkg.sv
// Shared types for the weight-ROM fetch sequencer: FSM states and the beat record
// that travels from the ROM read ports through the skid buffer to the MAC array.
package wt_ctrl_pkg;

    localparam int WT_PER_WORD = 9;
    localparam int WT_BITS     = 16;
    localparam int WORD_W      = WT_PER_WORD * WT_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              b_vld;
        logic              last;
    } beat_t;

endpackage

// File: rtl/wt_skid_buf.sv
// Two-entry FIFO of fetched beats; absorbs the ROM read latency under MAC back-pressure
// and accepts a push and a pop in the same cycle even when full.
module wt_skid_buf
    import wt_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  beat_t      in_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_beat,
    output logic [1:0] count
);

    beat_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign out_valid = (cnt_q != 2'd0);
    assign in_ready  = (cnt_q != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_beat  = mem_q[rd_ptr_q];
    assign count     = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload carries no reset; the top masks it with valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_beat;
    end

endmodule

// File: rtl/wt_fetch_ctrl.sv
// Weight ROM fetch sequencer: walks a window pairwise over the dual-port ROM, replays
// it cfg_reps times and streams word pairs to the MAC array through a skid buffer.
module wt_fetch_ctrl
    import wt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 144,
    parameter int DEPTH      = 76,
    parameter int REP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic [REP_WIDTH-1:0]  cfg_reps,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  wt_valid,
    input  logic                  wt_ready,
    output logic [DATA_WIDTH-1:0] wt_a,
    output logic [DATA_WIDTH-1:0] wt_b,
    output logic                  wt_b_vld,
    output logic                  wt_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    function automatic logic [ADDR_WIDTH-1:0] first_b(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ADDR_WIDTH-1:0] len);
        return (len == ADDR_WIDTH'(1)) ? base : base + 1'b1;
    endfunction

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q, len_q, beat_q, addr_a_q, addr_b_q;
    logic [REP_WIDTH-1:0]  reps_q, rep_q;
    logic                  in_flight_q, inf_bvld_q, inf_last_q;
    logic                  busy_q, done_q, err_q;

    logic [ADDR_WIDTH:0]   win_end;
    logic [ADDR_WIDTH-1:0] last_k, next_a_d, next_b_d;
    logic                  cfg_ok, last_beat, next_last, pop, issue, drain_done, buf_in_rdy;
    logic [1:0]            buf_cnt;
    beat_t                 push_beat, head_beat;

    assign win_end    = {1'b0, cfg_base} + {1'b0, cfg_len};
    assign cfg_ok     = (cfg_len != '0) && (cfg_reps != '0) &&
                        (win_end <= (ADDR_WIDTH+1)'(DEPTH));
    assign last_k     = (len_q - 1'b1) >> 1;
    assign last_beat  = (beat_q == last_k);
    assign next_last  = ((beat_q + 1'b1) == last_k);
    assign next_a_d   = addr_a_q + ADDR_WIDTH'(2);
    assign next_b_d   = (next_last && len_q[0]) ? next_a_d : next_a_d + 1'b1;
    assign pop        = wt_valid && wt_ready;
    // Credit counts the slot freed by this cycle's pop so steady streaming sustains 1 beat/clk.
    assign issue      = (state_q == FETCH) && buf_in_rdy &&
                        (({2'b0, in_flight_q} + {1'b0, buf_cnt}) < (3'd2 + {2'b0, pop}));
    assign drain_done = (state_q == DRAIN) && !in_flight_q &&
                        ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop));

    assign push_beat.a     = q_a;
    assign push_beat.b     = inf_bvld_q ? q_b : '0;
    assign push_beat.b_vld = inf_bvld_q;
    assign push_beat.last  = inf_last_q;

    wt_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_flight_q),
        .in_ready  (buf_in_rdy),
        .in_beat   (push_beat),
        .out_valid (wt_valid),
        .out_ready (wt_ready),
        .out_beat  (head_beat),
        .count     (buf_cnt)
    );

    assign wt_a     = wt_valid ? head_beat.a : '0;
    assign wt_b     = wt_valid ? head_beat.b : '0;
    assign wt_b_vld = wt_valid && head_beat.b_vld;
    assign wt_last  = wt_valid && head_beat.last;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            reps_q      <= '0;
            beat_q      <= '0;
            rep_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= ADDR_WIDTH'(1);
            in_flight_q <= 1'b0;
            inf_bvld_q  <= 1'b0;
            inf_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            in_flight_q <= issue;
            if (issue) begin
                inf_bvld_q <= !(last_beat && len_q[0]);
                inf_last_q <= last_beat;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            base_q   <= cfg_base;
                            len_q    <= cfg_len;
                            reps_q   <= cfg_reps;
                            beat_q   <= '0;
                            rep_q    <= '0;
                            addr_a_q <= cfg_base;
                            addr_b_q <= first_b(cfg_base, cfg_len);
                            busy_q   <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (last_beat) begin
                            beat_q   <= '0;
                            rep_q    <= rep_q + 1'b1;
                            addr_a_q <= base_q;
                            addr_b_q <= first_b(base_q, len_q);
                            if (rep_q == reps_q - 1'b1) state_q <= DRAIN;
                        end else begin
                            beat_q   <= beat_q + 1'b1;
                            addr_a_q <= next_a_d;
                            addr_b_q <= next_b_d;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wt_fetch_ctrl.sv
// Bench for wt_fetch_ctrl: random ROM contents, ready patterns and a beat-level
// scoreboard derived from the window / repetition rules.
module tb_wt_fetch_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 144;
    localparam int DEPTH = 76;
    localparam int RW    = 8;
    localparam int CW    = 320;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bv;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_base, cfg_len;
    logic [RW-1:0] cfg_reps;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q_a, q_b;
    logic          wt_valid;
    logic          wt_ready = 1'b0;
    logic [DW-1:0] wt_a, wt_b;
    logic          wt_b_vld, wt_last, busy, done, cfg_err;

    logic [DW-1:0] mem [DEPTH];
    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            s_cyc = 0;
    int            fv_cyc = -1;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            rdy_mode;
    logic          stall_prev = 1'b0;
    logic [2*DW+1:0] hold;

    wt_fetch_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_reps (cfg_reps),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .q_a      (q_a),
        .q_b      (q_b),
        .wt_valid (wt_valid),
        .wt_ready (wt_ready),
        .wt_a     (wt_a),
        .wt_b     (wt_b),
        .wt_b_vld (wt_b_vld),
        .wt_last  (wt_last),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_rd(input logic [AW-1:0] ad);
        return (int'(ad) < DEPTH) ? mem[ad] : '0;
    endfunction

    always @(posedge clk) begin
        q_a <= rom_rd(addr_a);
        q_b <= rom_rd(addr_b);
        wt_ready <= (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", CW'(busy), CW'(0));
            end
            if (cfg_err) err_cnt++;
            if (wt_valid && fv_cyc < s_cyc) fv_cyc = cyc;
            if (stall_prev)
                check("stall_hold", CW'({wt_valid, wt_a, wt_b, wt_b_vld, wt_last}), CW'({1'b1, hold}));
            if (wt_valid && wt_ready) begin
                check("beat_expected", CW'(exp_q.size() != 0), CW'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_a", CW'(wt_a), CW'(e.a));
                    check("beat_b", CW'(wt_b), CW'(e.b));
                    check("beat_flags", CW'({wt_b_vld, wt_last}), CW'({e.bv, e.last}));
                end
            end
            stall_prev = wt_valid && !wt_ready;
            hold = {wt_a, wt_b, wt_b_vld, wt_last};
        end
    end

    // Beats in order: per pass, word pairs (base+2k, base+2k+1), odd tail has no b word.
    task automatic push_expected(input int b, input int l, input int r);
        int nb = (l + 1) / 2;
        exp_t e;
        for (int rep = 0; rep < r; rep++) begin
            for (int k = 0; k < nb; k++) begin
                e.a    = mem[b + 2*k];
                e.bv   = (2*k + 1 < l);
                e.b    = e.bv ? mem[b + 2*k + 1] : '0;
                e.last = (k == nb - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int b, input int l, input int r);
        @(posedge clk);
        #1;
        cfg_base = AW'(b);
        cfg_len  = AW'(l);
        cfg_reps = RW'(r);
        start    = 1'b1;
        s_cyc    = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", CW'(done_cnt - d0), CW'(1));
    endtask

    task automatic run_window(input int b, input int l, input int r, input int budget, input bit timed);
        int d0 = done_cnt;
        push_expected(b, l, r);
        pulse_start(b, l, r);
        check("busy_after_start", CW'(busy), CW'(1));
        wait_done(d0, budget);
        check("queue_empty", CW'(exp_q.size()), CW'(0));
        if (timed) begin
            check("first_valid_lat", CW'(fv_cyc - s_cyc), CW'(2));
            check("done_lat", CW'(done_cyc - s_cyc), CW'(r * ((l + 1) / 2) + 2));
        end
    endtask

    task automatic reject(input int b, input int l, input int r);
        pulse_start(b, l, r);
        check("cfg_err_pulse", CW'(cfg_err), CW'(1));
        check("busy_on_reject", CW'(busy), CW'(0));
        @(posedge clk);
        #1;
        check("cfg_err_single", CW'(cfg_err), CW'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] t;
        int d0, e0;
        rst = 1'b1;
        start = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        cfg_reps = '0;
        rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom, $urandom};
            mem[i] = t[DW-1:0];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_a", CW'(addr_a), CW'(0));
        check("rst_addr_b", CW'(addr_b), CW'(1));
        check("rst_valid", CW'({wt_valid, wt_b_vld, wt_last}), CW'(0));
        check("rst_data", CW'({wt_a, wt_b}), CW'(0));
        check("rst_ctrl", CW'({busy, done, cfg_err}), CW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        rdy_mode = 1;
        run_window(0, 4, 1, 50, 1'b1);
        run_window(10, 3, 2, 50, 1'b1);
        run_window(5, 1, 3, 50, 1'b1);

        reject(70, 7, 1);
        reject(3, 0, 1);
        reject(3, 4, 0);
        reject(1, 76, 1);
        run_window(70, 6, 1, 50, 1'b1);
        run_window(0, 76, 1, 100, 1'b1);

        rdy_mode = 2;
        run_window(0, 76, 3, 3000, 1'b0);
        run_window(33, 11, 4, 1000, 1'b0);

        rdy_mode = 0;
        d0 = done_cnt;
        pulse_start(5, 20, 2);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", CW'({wt_valid, wt_b_vld, wt_last}), CW'(0));
        check("abort_data", CW'({wt_a, wt_b}), CW'(0));
        check("abort_ctrl", CW'({busy, done, cfg_err}), CW'(0));
        check("abort_addr", CW'({addr_a, addr_b}), CW'({7'd0, 7'd1}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_abort", CW'(done_cnt - d0), CW'(0));
        rdy_mode = 1;
        run_window(30, 5, 1, 50, 1'b1);

        rdy_mode = 2;
        d0 = done_cnt;
        e0 = err_cnt;
        push_expected(20, 9, 2);
        pulse_start(20, 9, 2);
        repeat (2) @(posedge clk);
        pulse_start(0, 0, 0);
        check("busy_ignores_bad_start", CW'({busy, cfg_err}), CW'({1'b1, 1'b0}));
        pulse_start(0, 2, 1);
        check("busy_ignores_start", CW'(busy), CW'(1));
        wait_done(d0, 500);
        repeat (8) @(negedge clk);
        check("single_done", CW'(done_cnt - d0), CW'(1));
        check("no_err_while_busy", CW'(err_cnt - e0), CW'(0));
        check("busy_queue_empty", CW'(exp_q.size()), CW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
